// File: rtl/alu_rs_scheduler.sv
// Reservation station for the ALU: buffers dispatched uops, snoops the ALU/LSB CDBs for
// operands, and issues the lowest-index ready entry into registered FU inputs each cycle.
module alu_rs_scheduler #(
  parameter int unsigned       RS_LOG  = 4,
  parameter int unsigned       OP_LOG  = 6,
  parameter int unsigned       ROB_LOG = 4,
  parameter logic [OP_LOG-1:0] OP_NOP  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy,
  input  logic               clear,
  input  logic               disp_valid,
  input  logic [OP_LOG-1:0]  disp_op,
  input  logic [31:0]        disp_Vj,
  input  logic [31:0]        disp_Vk,
  input  logic               disp_Qj_pend,
  input  logic               disp_Qk_pend,
  input  logic [ROB_LOG-1:0] disp_Qj,
  input  logic [ROB_LOG-1:0] disp_Qk,
  input  logic [31:0]        disp_Imm,
  input  logic [ROB_LOG-1:0] disp_DestRob,
  input  logic [31:0]        disp_PC,
  output logic               full,
  input  logic               alu_cdb_en,
  input  logic [ROB_LOG-1:0] alu_cdb_rob,
  input  logic [31:0]        alu_cdb_val,
  input  logic               lsb_cdb_en,
  input  logic [ROB_LOG-1:0] lsb_cdb_rob,
  input  logic [31:0]        lsb_cdb_val,
  output logic               RS_valid,
  output logic [OP_LOG-1:0]  RS_op,
  output logic [31:0]        RS_Vj,
  output logic [31:0]        RS_Vk,
  output logic [31:0]        RS_Imm,
  output logic [31:0]        RS_CurPC,
  output logic [ROB_LOG-1:0] RS_DestRob
);

  localparam int RsSize = 1 << RS_LOG;

  logic [RsSize-1:0]  r_busy;
  logic [RsSize-1:0]  r_qj_pend;
  logic [RsSize-1:0]  r_qk_pend;
  logic [OP_LOG-1:0]  r_op   [RsSize];
  logic [31:0]        r_vj   [RsSize];
  logic [31:0]        r_vk   [RsSize];
  logic [ROB_LOG-1:0] r_qj   [RsSize];
  logic [ROB_LOG-1:0] r_qk   [RsSize];
  logic [31:0]        r_imm  [RsSize];
  logic [ROB_LOG-1:0] r_dest [RsSize];
  logic [31:0]        r_pc   [RsSize];

  logic               r_rs_valid;
  logic [OP_LOG-1:0]  r_rs_op;
  logic [31:0]        r_rs_vj;
  logic [31:0]        r_rs_vk;
  logic [31:0]        r_rs_imm;
  logic [31:0]        r_rs_pc;
  logic [ROB_LOG-1:0] r_rs_dest;

  logic [RsSize-1:0]  w_ready;
  logic               w_iss_found;
  logic [RS_LOG-1:0]  w_iss_idx;
  logic               w_free_found;
  logic [RS_LOG-1:0]  w_free_idx;
  logic [RS_LOG:0]    w_count;
  logic               w_disp_fire;
  logic [32:0]        w_wj [RsSize];
  logic [32:0]        w_wk [RsSize];
  logic [32:0]        w_dj;
  logic [32:0]        w_dk;

  // Returns {pend, value} after snooping both CDBs; the ALU bus wins a tag tie.
  function automatic logic [32:0] snoop(input logic pend, input logic [ROB_LOG-1:0] tag,
                                        input logic [31:0] val,
                                        input logic a_en, input logic [ROB_LOG-1:0] a_rob,
                                        input logic [31:0] a_val,
                                        input logic l_en, input logic [ROB_LOG-1:0] l_rob,
                                        input logic [31:0] l_val);
    logic [32:0] res;
    res = {pend, val};
    if (pend && a_en && (a_rob == tag)) begin
      res = {1'b0, a_val};
    end else if (pend && l_en && (l_rob == tag)) begin
      res = {1'b0, l_val};
    end
    return res;
  endfunction

  assign w_ready = r_busy & ~r_qj_pend & ~r_qk_pend;

  always_comb begin
    w_iss_found  = 1'b0;
    w_iss_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_count      = '0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = RsSize - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_iss_found = 1'b1;
        w_iss_idx   = RS_LOG'(i);
      end
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = RS_LOG'(i);
      end
      w_count = w_count + (RS_LOG + 1)'(r_busy[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < RsSize; i++) begin
      w_wj[i] = snoop(r_qj_pend[i], r_qj[i], r_vj[i], alu_cdb_en, alu_cdb_rob, alu_cdb_val,
                      lsb_cdb_en, lsb_cdb_rob, lsb_cdb_val);
      w_wk[i] = snoop(r_qk_pend[i], r_qk[i], r_vk[i], alu_cdb_en, alu_cdb_rob, alu_cdb_val,
                      lsb_cdb_en, lsb_cdb_rob, lsb_cdb_val);
    end
    w_dj = snoop(disp_Qj_pend, disp_Qj, disp_Vj, alu_cdb_en, alu_cdb_rob, alu_cdb_val,
                 lsb_cdb_en, lsb_cdb_rob, lsb_cdb_val);
    w_dk = snoop(disp_Qk_pend, disp_Qk, disp_Vk, alu_cdb_en, alu_cdb_rob, alu_cdb_val,
                 lsb_cdb_en, lsb_cdb_rob, lsb_cdb_val);
  end

  assign w_disp_fire = disp_valid && (disp_op != OP_NOP) && w_free_found;
  // One slot of slack covers the dispatch already in flight in the decoder register.
  assign full        = (w_count >= (RS_LOG + 1)'(RsSize - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_qj_pend  <= '0;
      r_qk_pend  <= '0;
      for (int i = 0; i < RsSize; i++) begin
        r_op[i]   <= OP_NOP;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
        r_qj[i]   <= '0;
        r_qk[i]   <= '0;
        r_imm[i]  <= '0;
        r_dest[i] <= '0;
        r_pc[i]   <= '0;
      end
      r_rs_valid <= 1'b0;
      r_rs_op    <= OP_NOP;
      r_rs_vj    <= '0;
      r_rs_vk    <= '0;
      r_rs_imm   <= '0;
      r_rs_pc    <= '0;
      r_rs_dest  <= '0;
    end else if (rdy) begin
      if (clear) begin
        r_busy     <= '0;
        r_rs_valid <= 1'b0;
        r_rs_op    <= OP_NOP;
      end else begin
        for (int i = 0; i < RsSize; i++) begin
          if (r_busy[i]) begin
            {r_qj_pend[i], r_vj[i]} <= w_wj[i];
            {r_qk_pend[i], r_vk[i]} <= w_wk[i];
          end
        end
        if (w_iss_found) begin
          r_busy[w_iss_idx] <= 1'b0;
          r_rs_valid        <= 1'b1;
          r_rs_op           <= r_op[w_iss_idx];
          r_rs_vj           <= r_vj[w_iss_idx];
          r_rs_vk           <= r_vk[w_iss_idx];
          r_rs_imm          <= r_imm[w_iss_idx];
          r_rs_pc           <= r_pc[w_iss_idx];
          r_rs_dest         <= r_dest[w_iss_idx];
        end else begin
          r_rs_valid <= 1'b0;
          r_rs_op    <= OP_NOP;
        end
        // The free slot is never busy, so it cannot collide with wake-up or issue writes.
        if (w_disp_fire) begin
          r_busy[w_free_idx]                       <= 1'b1;
          r_op[w_free_idx]                         <= disp_op;
          {r_qj_pend[w_free_idx], r_vj[w_free_idx]} <= w_dj;
          {r_qk_pend[w_free_idx], r_vk[w_free_idx]} <= w_dk;
          r_qj[w_free_idx]                         <= disp_Qj;
          r_qk[w_free_idx]                         <= disp_Qk;
          r_imm[w_free_idx]                        <= disp_Imm;
          r_dest[w_free_idx]                       <= disp_DestRob;
          r_pc[w_free_idx]                         <= disp_PC;
        end
      end
    end
  end

  assign RS_valid   = r_rs_valid;
  assign RS_op      = r_rs_op;
  assign RS_Vj      = r_rs_vj;
  assign RS_Vk      = r_rs_vk;
  assign RS_Imm     = r_rs_imm;
  assign RS_CurPC   = r_rs_pc;
  assign RS_DestRob = r_rs_dest;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (rdy && !clear && disp_valid && (disp_op != OP_NOP)) |-> w_free_found);

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: directed vector table, hand-built corner sequences and
// randomized traffic, all compared against a behavioural reservation-station model.
module tb_alu_rs_scheduler;

  localparam logic [5:0] OpNop  = 6'd0;
  localparam logic [5:0] OpAddi = 6'd1;
  localparam logic [5:0] OpAdd  = 6'd2;

  logic        clk = 1'b0;
  logic        rst_n, rdy, clear, disp_valid;
  logic [5:0]  disp_op;
  logic [31:0] disp_Vj, disp_Vk, disp_Imm, disp_PC;
  logic        disp_Qj_pend, disp_Qk_pend;
  logic [3:0]  disp_Qj, disp_Qk, disp_DestRob;
  logic        full;
  logic        alu_cdb_en, lsb_cdb_en;
  logic [3:0]  alu_cdb_rob, lsb_cdb_rob;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        RS_valid;
  logic [5:0]  RS_op;
  logic [31:0] RS_Vj, RS_Vk, RS_Imm, RS_CurPC;
  logic [3:0]  RS_DestRob;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rs_scheduler dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_Vj(disp_Vj), .disp_Vk(disp_Vk),
    .disp_Qj_pend(disp_Qj_pend), .disp_Qk_pend(disp_Qk_pend), .disp_Qj(disp_Qj),
    .disp_Qk(disp_Qk), .disp_Imm(disp_Imm), .disp_DestRob(disp_DestRob), .disp_PC(disp_PC),
    .full(full),
    .alu_cdb_en(alu_cdb_en), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_en(lsb_cdb_en), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_val(lsb_cdb_val),
    .RS_valid(RS_valid), .RS_op(RS_op), .RS_Vj(RS_Vj), .RS_Vk(RS_Vk), .RS_Imm(RS_Imm),
    .RS_CurPC(RS_CurPC), .RS_DestRob(RS_DestRob)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        busy;
    logic [5:0]  op;
    logic [31:0] vj, vk, imm, pc;
    logic        jp, kp;
    logic [3:0]  qj, qk, dest;
  } ent_t;

  ent_t        m_rs [16];
  logic        m_valid;
  logic [5:0]  m_op;
  logic [31:0] m_vj, m_vk, m_imm, m_pc;
  logic [3:0]  m_dest;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rs[i].busy = 1'b0;
    m_valid = 1'b0; m_op = OpNop; m_vj = '0; m_vk = '0; m_imm = '0; m_pc = '0; m_dest = '0;
  endtask

  function automatic ent_t wake(input ent_t e);
    if (e.jp && alu_cdb_en && alu_cdb_rob == e.qj) begin e.vj = alu_cdb_val; e.jp = 1'b0; end
    else if (e.jp && lsb_cdb_en && lsb_cdb_rob == e.qj) begin e.vj = lsb_cdb_val; e.jp = 1'b0; end
    if (e.kp && alu_cdb_en && alu_cdb_rob == e.qk) begin e.vk = alu_cdb_val; e.kp = 1'b0; end
    else if (e.kp && lsb_cdb_en && lsb_cdb_rob == e.qk) begin e.vk = lsb_cdb_val; e.kp = 1'b0; end
    return e;
  endfunction

  function automatic logic model_full();
    int n = 0;
    for (int i = 0; i < 16; i++) if (m_rs[i].busy) n++;
    return n >= 15;
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_step();
    int sel = -1;
    int fr = -1;
    if (!rdy) return;
    if (clear) begin
      for (int i = 0; i < 16; i++) m_rs[i].busy = 1'b0;
      m_valid = 1'b0; m_op = OpNop;
      return;
    end
    for (int i = 0; i < 16; i++) begin
      if (sel < 0 && m_rs[i].busy && !m_rs[i].jp && !m_rs[i].kp) sel = i;
      if (fr < 0 && !m_rs[i].busy) fr = i;
    end
    if (sel >= 0) begin
      m_valid = 1'b1; m_op = m_rs[sel].op; m_vj = m_rs[sel].vj; m_vk = m_rs[sel].vk;
      m_imm = m_rs[sel].imm; m_pc = m_rs[sel].pc; m_dest = m_rs[sel].dest;
      m_rs[sel].busy = 1'b0;
    end else begin
      m_valid = 1'b0; m_op = OpNop;
    end
    for (int i = 0; i < 16; i++) if (m_rs[i].busy) m_rs[i] = wake(m_rs[i]);
    if (disp_valid && disp_op != OpNop && fr >= 0) begin
      ent_t e;
      e.busy = 1'b1; e.op = disp_op; e.vj = disp_Vj; e.vk = disp_Vk; e.imm = disp_Imm;
      e.pc = disp_PC; e.jp = disp_Qj_pend; e.kp = disp_Qk_pend; e.qj = disp_Qj;
      e.qk = disp_Qk; e.dest = disp_DestRob;
      m_rs[fr] = wake(e);
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_check();
    chk("model RS_valid", 32'(RS_valid), 32'(m_valid));
    chk("model RS_op", 32'(RS_op), 32'(m_op));
    if (m_valid) begin
      chk("model RS_Vj", RS_Vj, m_vj);
      chk("model RS_Vk", RS_Vk, m_vk);
      chk("model RS_Imm", RS_Imm, m_imm);
      chk("model RS_CurPC", RS_CurPC, m_pc);
      chk("model RS_DestRob", 32'(RS_DestRob), 32'(m_dest));
    end
    chk("model full", 32'(full), 32'(model_full()));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic set_idle();
    rdy = 1'b1; clear = 1'b0; disp_valid = 1'b0; disp_op = OpNop;
    disp_Vj = '0; disp_Vk = '0; disp_Imm = '0; disp_PC = '0;
    disp_Qj_pend = 1'b0; disp_Qk_pend = 1'b0; disp_Qj = '0; disp_Qk = '0; disp_DestRob = '0;
    alu_cdb_en = 1'b0; alu_cdb_rob = '0; alu_cdb_val = '0;
    lsb_cdb_en = 1'b0; lsb_cdb_rob = '0; lsb_cdb_val = '0;
  endtask

  function automatic logic [31:0] pc_of(input logic [3:0] dest);
    return 32'h1000 + (32'(dest) << 2);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        dv;
    logic [5:0]  op;
    logic [3:0]  dest;
    logic [31:0] vj, vk, imm;
    logic        jp;
    logic [3:0]  qj;
    logic        kp;
    logic [3:0]  qk;
    logic        ae;
    logic [3:0]  ar;
    logic [31:0] av;
    logic        le;
    logic [3:0]  lr;
    logic [31:0] lv;
    logic        ev;
    logic [5:0]  eop;
    logic [31:0] evj, evk, eimm;
    logic [3:0]  edest;
  } vec_t;

  function automatic vec_t idle_v();
    vec_t v = '0;
    return v;
  endfunction

  function automatic vec_t dsp(input logic [5:0] op, input logic [3:0] dest,
                               input logic [31:0] vj, input logic [31:0] vk,
                               input logic [31:0] imm, input logic jp, input logic [3:0] qj,
                               input logic kp, input logic [3:0] qk);
    vec_t v = '0;
    v.dv = 1'b1; v.op = op; v.dest = dest; v.vj = vj; v.vk = vk; v.imm = imm;
    v.jp = jp; v.qj = qj; v.kp = kp; v.qk = qk;
    return v;
  endfunction

  function automatic vec_t cdb(input vec_t v, input logic ae, input logic [3:0] ar,
                               input logic [31:0] av, input logic le, input logic [3:0] lr,
                               input logic [31:0] lv);
    v.ae = ae; v.ar = ar; v.av = av; v.le = le; v.lr = lr; v.lv = lv;
    return v;
  endfunction

  function automatic vec_t expv(input vec_t v, input logic [5:0] op, input logic [31:0] vj,
                                input logic [31:0] vk, input logic [31:0] imm,
                                input logic [3:0] dest);
    v.ev = 1'b1; v.eop = op; v.evj = vj; v.evk = vk; v.eimm = imm; v.edest = dest;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    set_idle();
    disp_valid = v.dv; disp_op = v.op; disp_DestRob = v.dest; disp_PC = pc_of(v.dest);
    disp_Vj = v.vj; disp_Vk = v.vk; disp_Imm = v.imm;
    disp_Qj_pend = v.jp; disp_Qj = v.qj; disp_Qk_pend = v.kp; disp_Qk = v.qk;
    alu_cdb_en = v.ae; alu_cdb_rob = v.ar; alu_cdb_val = v.av;
    lsb_cdb_en = v.le; lsb_cdb_rob = v.lr; lsb_cdb_val = v.lv;
  endtask

  vec_t vq[$];

  initial begin
    set_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset RS_valid", 32'(RS_valid), 32'd0);
    chk("reset RS_op", 32'(RS_op), 32'(OpNop));
    chk("reset RS_Vj", RS_Vj, 32'd0);
    chk("reset RS_Vk", RS_Vk, 32'd0);
    chk("reset RS_Imm", RS_Imm, 32'd0);
    chk("reset RS_CurPC", RS_CurPC, 32'd0);
    chk("reset RS_DestRob", 32'(RS_DestRob), 32'd0);
    chk("reset full", 32'(full), 32'd0);
    rst_n = 1'b1;

    // Ready ADDI, LSB wake-up, dispatch bypass, ALU-over-LSB priority, NOP ignored.
    vq.push_back(dsp(OpAddi, 4'd4, 32'd5, 32'd0, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0));
    vq.push_back(expv(idle_v(), OpAddi, 32'd5, 32'd0, 32'd7, 4'd4));
    vq.push_back(idle_v());
    vq.push_back(dsp(OpAdd, 4'd5, 32'd0, 32'd11, 32'd0, 1'b1, 4'd3, 1'b0, 4'd0));
    vq.push_back(idle_v());
    vq.push_back(idle_v());
    vq.push_back(cdb(idle_v(), 1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'h100));
    vq.push_back(expv(idle_v(), OpAdd, 32'h100, 32'd11, 32'd0, 4'd5));
    vq.push_back(idle_v());
    vq.push_back(cdb(dsp(OpAdd, 4'd6, 32'd1, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'd9),
                     1'b1, 4'd9, 32'd42, 1'b0, 4'd0, 32'd0));
    vq.push_back(expv(idle_v(), OpAdd, 32'd1, 32'd42, 32'd0, 4'd6));
    vq.push_back(idle_v());
    vq.push_back(dsp(OpAdd, 4'd7, 32'd0, 32'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0));
    vq.push_back(cdb(idle_v(), 1'b1, 4'd2, 32'hAA, 1'b1, 4'd2, 32'hBB));
    vq.push_back(expv(idle_v(), OpAdd, 32'hAA, 32'd0, 32'd0, 4'd7));
    vq.push_back(idle_v());
    vq.push_back(dsp(OpNop, 4'd8, 32'd3, 32'd3, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0));
    vq.push_back(idle_v());

    foreach (vq[i]) begin
      apply_vec(vq[i]);
      tick();
      chk("vec RS_valid", 32'(RS_valid), 32'(vq[i].ev));
      if (vq[i].ev) begin
        chk("vec RS_op", 32'(RS_op), 32'(vq[i].eop));
        chk("vec RS_Vj", RS_Vj, vq[i].evj);
        chk("vec RS_Vk", RS_Vk, vq[i].evk);
        chk("vec RS_Imm", RS_Imm, vq[i].eimm);
        chk("vec RS_DestRob", 32'(RS_DestRob), 32'(vq[i].edest));
        chk("vec RS_CurPC", RS_CurPC, pc_of(vq[i].edest));
      end else begin
        chk("vec RS_op idle", 32'(RS_op), 32'(OpNop));
      end
      chk("vec full", 32'(full), 32'd0);
    end

    // Fill 15 entries waiting on tags 0..14.
    for (int i = 0; i < 15; i++) begin
      set_idle();
      disp_valid = 1'b1; disp_op = OpAdd; disp_Qj_pend = 1'b1; disp_Qj = 4'(i);
      disp_Vk = 32'(i); disp_DestRob = 4'(i); disp_PC = pc_of(4'(i));
      tick();
      chk("fill full", 32'(full), 32'(i == 14));
      chk("fill no issue", 32'(RS_valid), 32'd0);
    end
    set_idle();
    alu_cdb_en = 1'b1; alu_cdb_rob = 4'd2; alu_cdb_val = 32'h222;
    lsb_cdb_en = 1'b1; lsb_cdb_rob = 4'd7; lsb_cdb_val = 32'h777;
    tick();
    chk("arb wake cycle valid", 32'(RS_valid), 32'd0);
    chk("arb still full", 32'(full), 32'd1);
    set_idle();
    tick();
    chk("arb first valid", 32'(RS_valid), 32'd1);
    chk("arb first dest", 32'(RS_DestRob), 32'd2);
    chk("arb first Vj", RS_Vj, 32'h222);
    chk("arb full drops", 32'(full), 32'd0);
    tick();
    chk("arb second valid", 32'(RS_valid), 32'd1);
    chk("arb second dest", 32'(RS_DestRob), 32'd7);
    chk("arb second Vj", RS_Vj, 32'h777);
    tick();
    chk("arb drained", 32'(RS_valid), 32'd0);

    // Flush with an issue pending and a simultaneous dispatch.
    set_idle();
    alu_cdb_en = 1'b1; alu_cdb_rob = 4'd0; alu_cdb_val = 32'h5;
    tick();
    chk("flush pre valid", 32'(RS_valid), 32'd0);
    set_idle();
    clear = 1'b1; disp_valid = 1'b1; disp_op = OpAddi; disp_Vj = 32'd9; disp_DestRob = 4'd15;
    tick();
    chk("flush RS_valid", 32'(RS_valid), 32'd0);
    chk("flush RS_op", 32'(RS_op), 32'(OpNop));
    chk("flush full", 32'(full), 32'd0);
    for (int t = 0; t < 16; t++) begin
      set_idle();
      alu_cdb_en = 1'b1; alu_cdb_rob = 4'(t); alu_cdb_val = 32'(t);
      tick();
      chk("flush nothing issues", 32'(RS_valid), 32'd0);
    end

    // rdy low freezes everything, including an incoming dispatch.
    set_idle();
    disp_valid = 1'b1; disp_op = OpAddi; disp_Vj = 32'h11; disp_DestRob = 4'd1;
    disp_PC = pc_of(4'd1);
    tick();
    disp_Vj = 32'h22; disp_DestRob = 4'd2; disp_PC = pc_of(4'd2);
    tick();
    chk("rdy pre valid", 32'(RS_valid), 32'd1);
    rdy = 1'b0; disp_Vj = 32'h33; disp_DestRob = 4'd3; disp_PC = pc_of(4'd3);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("rdy hold valid", 32'(RS_valid), 32'd1);
      chk("rdy hold dest", 32'(RS_DestRob), 32'd1);
      chk("rdy hold Vj", RS_Vj, 32'h11);
    end
    set_idle();
    tick();
    chk("rdy resume dest", 32'(RS_DestRob), 32'd2);
    chk("rdy resume Vj", RS_Vj, 32'h22);
    tick();
    chk("rdy dropped dispatch", 32'(RS_valid), 32'd0);

    // Asynchronous reset between clock edges.
    set_idle();
    disp_valid = 1'b1; disp_op = OpAddi; disp_Vj = 32'h44; disp_DestRob = 4'd9;
    disp_PC = pc_of(4'd9);
    tick();
    disp_Qj_pend = 1'b1; disp_Qj = 4'd5; disp_DestRob = 4'd10;
    tick();
    chk("arst pre valid", 32'(RS_valid), 32'd1);
    set_idle();
    #1 rst_n = 1'b0;
    #1;
    chk("arst RS_valid", 32'(RS_valid), 32'd0);
    chk("arst RS_op", 32'(RS_op), 32'(OpNop));
    chk("arst RS_DestRob", 32'(RS_DestRob), 32'd0);
    chk("arst RS_Vj", RS_Vj, 32'd0);
    #1 rst_n = 1'b1;
    model_reset();
    alu_cdb_en = 1'b1; alu_cdb_rob = 4'd5; alu_cdb_val = 32'h1;
    tick();
    tick();
    chk("arst entries gone", 32'(RS_valid), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rdy          = ($urandom_range(9) != 0);
      clear        = ($urandom_range(49) == 0);
      disp_valid   = !model_full() && ($urandom_range(9) < 6);
      disp_op      = 6'($urandom_range(3));
      disp_Vj      = $urandom;
      disp_Vk      = $urandom;
      disp_Imm     = $urandom;
      disp_PC      = $urandom;
      disp_Qj_pend = 1'($urandom_range(1));
      disp_Qk_pend = 1'($urandom_range(1));
      disp_Qj      = 4'($urandom_range(7));
      disp_Qk      = 4'($urandom_range(7));
      disp_DestRob = 4'($urandom);
      alu_cdb_en   = ($urandom_range(9) < 4);
      alu_cdb_rob  = 4'($urandom_range(7));
      alu_cdb_val  = $urandom;
      lsb_cdb_en   = ($urandom_range(9) < 4);
      lsb_cdb_rob  = 4'($urandom_range(7));
      lsb_cdb_val  = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
